// File: rtl/pic_ack_sequencer_if.sv
// CPU-pin / priority-resolver side bundle of the PIC acknowledge sequencer.
// The slave modport belongs to the sequencer; the master modport belongs to its environment.
interface pic_ack_sequencer_if;
    logic endOfinit;
    logic SNGL;
    logic en;
    logic cas_match;
    logic aeoi;
    logic int_req;
    logic inta_n;

    logic INT;
    logic imp1;
    logic endOfimp1;
    logic imp2;
    logic endOfimp2;
    logic data_oe;
    logic cas_oe;
    logic aeoi_clr;
    logic busy;
    logic err;

    modport slave (
        input  endOfinit, SNGL, en, cas_match, aeoi, int_req, inta_n,
        output INT, imp1, endOfimp1, imp2, endOfimp2, data_oe, cas_oe, aeoi_clr, busy, err
    );

    modport master (
        output endOfinit, SNGL, en, cas_match, aeoi, int_req, inta_n,
        input  INT, imp1, endOfimp1, imp2, endOfimp2, data_oe, cas_oe, aeoi_clr, busy, err
    );
endinterface

// File: rtl/pic_ack_sequencer.sv
// 8259 interrupt-acknowledge sequencer: raises INT, synchronizes INTA and walks the
// two-pulse acknowledge cycle, producing registered strobes and bus-driver enables.
module pic_ack_sequencer #(
    parameter int unsigned GAP_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pic_ack_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_P1,
        S_GAP,
        S_P2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         sync_q;
    logic               fall_c, rise_c;

    logic int_q,  int_d;
    logic imp1_q, imp1_d;
    logic eoi1_q, eoi1_d;
    logic imp2_q, imp2_d;
    logic eoi2_q, eoi2_d;
    logic doe_q,  doe_d;
    logic coe_q,  coe_d;
    logic aclr_q, aclr_d;
    logic busy_q, busy_d;
    logic err_q,  err_d;

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], bus.inta_n};
        end
    end

    assign fall_c =  sync_q[2] & ~sync_q[1];
    assign rise_c = ~sync_q[2] &  sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            int_q   <= 1'b0;
            imp1_q  <= 1'b0;
            eoi1_q  <= 1'b0;
            imp2_q  <= 1'b0;
            eoi2_q  <= 1'b0;
            doe_q   <= 1'b0;
            coe_q   <= 1'b0;
            aclr_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            imp1_q  <= imp1_d;
            eoi1_q  <= eoi1_d;
            imp2_q  <= imp2_d;
            eoi2_q  <= eoi2_d;
            doe_q   <= doe_d;
            coe_q   <= coe_d;
            aclr_q  <= aclr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next state and next registered outputs; levels are decoded from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        imp1_d  = 1'b0;
        eoi1_d  = 1'b0;
        imp2_d  = 1'b0;
        eoi2_d  = 1'b0;
        aclr_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (fall_c && !bus.int_req) begin
                    err_d = 1'b1;
                end else if (bus.endOfinit) begin
                    if (fall_c) begin
                        state_d = S_P1;
                        imp1_d  = 1'b1;
                    end else if (bus.int_req) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (fall_c) begin
                    state_d = S_P1;
                    imp1_d  = 1'b1;
                end else if (!bus.int_req) begin
                    state_d = S_IDLE;
                end
            end
            S_P1: begin
                if (rise_c) begin
                    state_d = S_GAP;
                    eoi1_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall_c) begin
                    state_d = S_P2;
                    imp2_d  = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_P2: begin
                if (rise_c) begin
                    state_d = S_IDLE;
                    eoi2_d  = 1'b1;
                    aclr_d  = bus.aeoi;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        int_d  = (state_d == S_REQ);
        busy_d = (state_d == S_P1) || (state_d == S_GAP) || (state_d == S_P2);
        coe_d  = busy_d & bus.en & ~bus.SNGL;
        // Data bus stays driven through the endOfimp2 cycle
        doe_d  = ((state_d == S_P2) | eoi2_d) &
                 (bus.SNGL | (~bus.en & bus.cas_match));
    end

    assign bus.INT       = int_q;
    assign bus.imp1      = imp1_q;
    assign bus.endOfimp1 = eoi1_q;
    assign bus.imp2      = imp2_q;
    assign bus.endOfimp2 = eoi2_q;
    assign bus.data_oe   = doe_q;
    assign bus.cas_oe    = coe_q;
    assign bus.aeoi_clr  = aclr_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule
